// File: rtl/out_display_if.sv
// Bus between the CPU output register and the decimal display driver.
// The CPU side uses master; out_display uses slave.
interface out_display_if;
    logic [7:0]  qreg;
    logic        doOut;
    logic        busy;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  digit_en;

    modport master (
        output qreg,
        output doOut,
        input  busy,
        input  bcd,
        input  seg,
        input  digit_en
    );

    modport slave (
        input  qreg,
        input  doOut,
        output busy,
        output bcd,
        output seg,
        output digit_en
    );
endinterface

// File: rtl/out_display.sv
// Converts each OUT value to three BCD digits with a one-step-per-clock double-dabble
// and scans them onto a multiplexed 3-digit 7-segment display.
module out_display #(
    parameter int unsigned REFRESH_DIV    = 1024,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LEADING  = 1'b0
) (
    input logic          clk,
    input logic          reset,
    out_display_if.slave bus
);

    localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {StIdle, StConv} state_e;

    state_e      state_q, state_d;
    logic [19:0] shift_q, shift_d;
    logic [2:0]  count_q, count_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_val_q, pend_val_d;
    logic [11:0] bcd_q, bcd_d;
    logic [19:0] step;

    logic [CntW-1:0] refresh_q, refresh_d;
    logic [1:0]      idx_q, idx_d;
    logic [6:0]      seg_q, seg_d;
    logic [2:0]      en_q, en_d;
    logic [3:0]      digit;
    logic            blank;

    // One double-dabble iteration over the 12-bit BCD field above the binary byte.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5) begin
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_map(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            bcd_q      <= bcd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        bcd_d      = bcd_q;
        step       = dd_step(shift_q);
        case (state_q)
            StIdle: begin
                if (bus.doOut) begin
                    shift_d = {12'b0, bus.qreg};
                    count_d = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
                shift_d = step;
                count_d = count_q + 3'd1;
                if (bus.doOut) begin
                    pend_d     = 1'b1;
                    pend_val_d = bus.qreg;
                end
                if (count_q == 3'd7) begin
                    bcd_d = step[19:8];
                    // Queued value goes first; a doOut on this edge then becomes the new queue.
                    if (pend_q) begin
                        shift_d = {12'b0, pend_val_q};
                        count_d = '0;
                        pend_d  = bus.doOut;
                    end else if (bus.doOut) begin
                        shift_d = {12'b0, bus.qreg};
                        count_d = '0;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        refresh_d = refresh_q + CntW'(1);
        idx_d     = idx_q;
        if (refresh_q == CntW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            idx_d     = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    always_comb begin
        digit = bcd_q[3:0];
        blank = 1'b0;
        case (idx_q)
            2'd1: begin
                digit = bcd_q[7:4];
                blank = BLANK_LEADING && (bcd_q[11:4] == 8'h00);
            end
            2'd2: begin
                digit = bcd_q[11:8];
                blank = BLANK_LEADING && (bcd_q[11:8] == 4'h0);
            end
            default: begin
                digit = bcd_q[3:0];
                blank = 1'b0;
            end
        endcase
        seg_d = blank ? 7'h00 : seg_map(digit);
        en_d  = 3'b001 << idx_q;
        if (SEG_ACTIVE_LOW) begin
            seg_d = ~seg_d;
            en_d  = ~en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_q <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
            en_q      <= SEG_ACTIVE_LOW ? 3'h7 : 3'h0;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            en_q      <= en_d;
        end
    end

    assign bus.busy     = (state_q == StConv);
    assign bus.bcd      = bcd_q;
    assign bus.seg      = seg_q;
    assign bus.digit_en = en_q;

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display: conversion timing, queueing, reset abort, scan and blanking.
// Instance 0 is active-low unblanked, instance 1 is active-high with leading-zero blanking.
module tb_out_display;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] qreg = 8'h00;
    logic       do_out = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    out_display_if if0 ();
    out_display_if if1 ();

    assign if0.qreg  = qreg;
    assign if0.doOut = do_out;
    assign if1.qreg  = qreg;
    assign if1.doOut = do_out;

    out_display #(
        .REFRESH_DIV   (4),
        .SEG_ACTIVE_LOW(1'b1),
        .BLANK_LEADING (1'b0)
    ) u_dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (if0)
    );

    out_display #(
        .REFRESH_DIV   (4),
        .SEG_ACTIVE_LOW(1'b0),
        .BLANK_LEADING (1'b1)
    ) u_dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (if1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] cur_en(input int inst);
        return (inst == 1) ? if1.digit_en : if0.digit_en;
    endfunction

    function automatic logic [6:0] cur_seg(input int inst);
        return (inst == 1) ? if1.seg : if0.seg;
    endfunction

    // Single conversion from idle: busy over E..E+7, result and idle after E+8.
    task automatic convert(input logic [7:0] v, input logic [11:0] exp, input string tag);
        qreg   = v;
        do_out = 1'b1;
        tick();
        do_out = 1'b0;
        qreg   = ~v;
        check({tag, " busy@E"}, 32'(if0.busy), 32'd1);
        repeat (7) tick();
        check({tag, " busy@E+7"}, 32'(if0.busy), 32'd1);
        tick();
        check({tag, " bcd0"}, 32'(if0.bcd), 32'(exp));
        check({tag, " bcd1"}, 32'(if1.bcd), 32'(exp));
        check({tag, " idle"}, 32'(if0.busy), 32'd0);
    endtask

    // Sync to the cycle the units digit is first selected, then check 12 scan cycles.
    task automatic scan_check(input int inst, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input string tag);
        logic [6:0] exp_s [3];
        logic [2:0] exp_e [3];
        logic [2:0] prev;
        logic       found;
        exp_s[0] = s0;
        exp_s[1] = s1;
        exp_s[2] = s2;
        for (int d = 0; d < 3; d++) begin
            exp_e[d] = 3'(1 << d);
            if (inst == 0) exp_e[d] = ~exp_e[d];
        end
        found = 1'b0;
        prev  = cur_en(inst);
        for (int n = 0; n < 24 && !found; n++) begin
            tick();
            if (cur_en(inst) == exp_e[0] && prev != exp_e[0]) found = 1'b1;
            else prev = cur_en(inst);
        end
        check({tag, " sync"}, 32'(found), 32'd1);
        if (found) begin
            for (int k = 0; k < 12; k++) begin
                if (k > 0) tick();
                check({tag, " digit_en"}, 32'(cur_en(inst)), 32'(exp_e[k/4]));
                check({tag, " seg"}, 32'(cur_seg(inst)), 32'(exp_s[k/4]));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held three cycles.
        repeat (3) tick();
        check("rst busy", 32'(if0.busy), 32'd0);
        check("rst bcd", 32'(if0.bcd), 32'h000);
        check("rst seg0", 32'(if0.seg), 32'h7F);
        check("rst en0", 32'(if0.digit_en), 32'h7);
        check("rst seg1", 32'(if1.seg), 32'h00);
        check("rst en1", 32'(if1.digit_en), 32'h0);
        reset = 1'b0;
        tick();
        check("first en0", 32'(if0.digit_en), 32'h6);
        check("first seg0", 32'(if0.seg), 32'h40);
        check("first en1", 32'(if1.digit_en), 32'h1);

        convert(8'hFF, 12'h255, "conv FF");
        scan_check(0, 7'h12, 7'h12, 7'h24, "scan 255");
        convert(8'h00, 12'h000, "conv 00");
        convert(8'h0A, 12'h010, "conv 0A");
        convert(8'h64, 12'h100, "conv 64");
        scan_check(1, 7'h3F, 7'h3F, 7'h06, "blank 100");
        convert(8'h99, 12'h153, "conv 99");

        // Overlap: pending keeps only the last request.
        qreg = 8'h12; do_out = 1'b1; tick();
        do_out = 1'b0; qreg = 8'hAA; tick(); tick();
        qreg = 8'h34; do_out = 1'b1; tick();
        do_out = 1'b0; tick();
        qreg = 8'h56; do_out = 1'b1; tick();
        do_out = 1'b0; qreg = 8'hBB; tick(); tick(); tick();
        check("ovl bcd@E+8", 32'(if0.bcd), 32'h018);
        check("ovl busy@E+8", 32'(if0.busy), 32'd1);
        repeat (7) tick();
        check("ovl busy@E+15", 32'(if0.busy), 32'd1);
        check("ovl bcd@E+15", 32'(if0.bcd), 32'h018);
        tick();
        check("ovl bcd@E+16", 32'(if0.bcd), 32'h086);
        check("ovl idle", 32'(if0.busy), 32'd0);

        // Request landing exactly on the completion edge.
        qreg = 8'hC8; do_out = 1'b1; tick();
        do_out = 1'b0; qreg = 8'h00; repeat (7) tick();
        qreg = 8'h07; do_out = 1'b1; tick();
        do_out = 1'b0; qreg = 8'hCC;
        check("col bcd@E+8", 32'(if0.bcd), 32'h200);
        check("col busy@E+8", 32'(if0.busy), 32'd1);
        repeat (4) tick();
        check("col busy@E+12", 32'(if0.busy), 32'd1);
        repeat (4) tick();
        check("col bcd@E+16", 32'(if0.bcd), 32'h007);
        check("col idle", 32'(if0.busy), 32'd0);

        // Reset mid-conversion with a value queued.
        qreg = 8'hFF; do_out = 1'b1; tick();
        do_out = 1'b0; tick();
        qreg = 8'h33; do_out = 1'b1; tick();
        do_out = 1'b0; tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        check("abort bcd", 32'(if0.bcd), 32'h000);
        check("abort busy", 32'(if0.busy), 32'd0);
        repeat (12) tick();
        check("abort bcd later", 32'(if0.bcd), 32'h000);
        check("abort busy later", 32'(if0.busy), 32'd0);

        convert(8'h07, 12'h007, "conv 07");
        scan_check(1, 7'h07, 7'h00, 7'h00, "blank 007");
        scan_check(0, 7'h78, 7'h40, 7'h40, "scan 007");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_display.md
Name: out_display

Overview:
- Downstream consumer of the nic8 output register (qreg).
- On each OUT instruction (doOut strobe) it converts the 8-bit value to three BCD digits using a sequential double-dabble, one step per clock.
- It then drives a time-multiplexed 3-digit 7-segment display, showing the same %03d decimal value the simulation prints.
- Synthesisable; sits beside the CPU core on the board top level.

Parameters:
- REFRESH_DIV, 1024, clocks each digit stays lit before the scan advances (must be >= 2).
- SEG_ACTIVE_LOW, 1, when 1 the seg and digit_en outputs are inverted (common-anode board).
- BLANK_LEADING, 0, when 1 leading zeros are blanked (units digit is never blanked).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- qreg  input  8  CPU output register value.
- doOut  input  1  CPU control bit; high for the cycle in which qreg is loaded.
- busy  output  1  conversion in progress.
- bcd  output  12  last completed conversion: [11:8] hundreds, [7:4] tens, [3:0] units.
- seg  output  7  segments {g,f,e,d,c,b,a} for the currently selected digit.
- digit_en  output  3  one-hot digit select: bit0 units, bit1 tens, bit2 hundreds.

Behaviour:
- Reset (synchronous, active-high) clears everything:
  - busy=0, bcd=0, pending=0, step count=0.
  - Refresh counter=0, digit index=0.
  - seg and digit_en = all segments/digits off (logical 0, inverted per SEG_ACTIVE_LOW).
  - Reset asserted mid-conversion aborts the conversion and discards any pending value. bcd returns to 0.
- Capture:
  - The value qreg has on the edge where doOut=1 is the value converted.
  - qreg is sampled on that same edge; the bench must not assume qreg is stable afterwards.
- Conversion FSM, states IDLE and CONV:
  - IDLE, doOut=1 at edge E: load shift register {12'b0, qreg}, count=0, busy=1, go to CONV.
  - CONV, each edge: add 3 to every BCD nibble >= 5, then shift left 1; count++.
  - The 8th CONV step falls on edge E+8. On that edge bcd is written with the final nibbles, so bcd is valid after edge E+8.
  - Also on edge E+8: if pending=0, busy=0 and go to IDLE. If pending=1, load the pending value, clear pending, count=0, and stay in CONV (busy remains 1).
  - doOut=1 while in CONV (including on the completion edge): store qreg in the single-entry pending register and set pending. The last doOut wins.
  - A doOut on the completion edge with pending already set overwrites pending; it does not restart the current conversion.
- Arithmetic: input 0..255 gives hundreds 0..2, tens 0..9, units 0..9. Nibble values above 9 never appear in bcd.
- Scan:
  - The refresh counter runs 0..REFRESH_DIV-1 continuously, independent of busy.
  - On wrap the digit index advances 0->1->2->0 (index 3 is never reached).
  - seg and digit_en are registered: they reflect the index and bcd values of the previous edge (1-cycle latency).
  - bcd changes mid-scan take effect on the next registered update. No tearing beyond that single cycle.
- Segment map (active-high form, {g..a}):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66.
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Blanking (BLANK_LEADING=1):
  - Hundreds is blank when it is 0.
  - Tens is blank when both hundreds and tens are 0.
  - A blanked digit drives seg=00 (inverted per polarity), but its digit_en still asserts.

Test Plan:
- Reset values: hold reset 3 cycles -> busy=0, bcd=000, seg=7F and digit_en=7 (SEG_ACTIVE_LOW=1). Release -> first digit_en=6 (units) one cycle after release.
- Single conversion: doOut=1, qreg=FF at edge E -> busy=1 over edges E..E+7, bcd=255 and busy=0 after E+8. Repeat with 00 -> 000, 0A -> 010, 64 -> 100, 99 -> 153.
- Overlap: qreg=12 at E, qreg=34 at E+3, qreg=56 at E+5 -> bcd=018 at E+8, busy stays 1, bcd=086 at E+16, busy=0 after E+16.
- Completion-edge collision: doOut with qreg=07 exactly on the completion edge of a conversion of C8 -> bcd=200, then bcd=007 eight edges later, busy continuously 1.
- Scan, REFRESH_DIV=4: digit_en (active-low) cycles 6,5,3 every 4 clocks. With bcd=255, seg shows 6D (units), 6D (tens), 5B (hundreds), inverted.
- Reset mid-conversion and blanking: reset at E+4 -> bcd=000, busy=0, no later update. With BLANK_LEADING=1 and value 07 -> hundreds and tens seg blank, units 07 (active-high form).
